// File: rtl/int_mc.sv
// int_mc: multi-channel integrator for channel-interleaved streams,
// continuous (CIC integrator) or integrate-and-dump with runtime block length.
module int_mc #(
    parameter int W  = 64,
    parameter int CH = 4,
    parameter int CW = (CH > 1) ? $clog2(CH) : 1,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  d,
    input  logic          vld,
    input  logic          clr,
    input  logic [CW-1:0] nsel,
    input  logic          mode,
    input  logic [LW-1:0] len,
    output logic [W-1:0]  q,
    output logic          qvld,
    output logic [CW-1:0] qch,
    output logic          qlast
);
    localparam logic [CW-1:0] NMAX = CW'(CH - 1);

    logic [W-1:0]  acc_q [CH];
    logic [W-1:0]  sum_d, q_q;
    logic [CW-1:0] chn_q, chn_d, nsel_q, qch_q;
    logic [LW-1:0] fcnt_q, fcnt_d, len_q;
    logic          mode_q, qvld_q, qlast_q, last, blast;

    // Dump mode restarts the block on the first frame instead of adding.
    always_comb begin
        last   = chn_q == nsel_q;
        blast  = fcnt_q == len_q - LW'(1);
        sum_d  = (mode_q && fcnt_q == '0) ? d : acc_q[chn_q] + d;
        chn_d  = last ? '0 : chn_q + CW'(1);
        fcnt_d = !last ? fcnt_q : (!mode_q || blast) ? '0 : fcnt_q + LW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) acc_q[i] <= '0;
            chn_q   <= '0;
            fcnt_q  <= '0;
            nsel_q  <= NMAX;
            mode_q  <= 1'b0;
            len_q   <= LW'(1);
            q_q     <= '0;
            qvld_q  <= 1'b0;
            qch_q   <= '0;
            qlast_q <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < CH; i++) acc_q[i] <= '0;
            chn_q  <= '0;
            fcnt_q <= '0;
            nsel_q <= (int'(nsel) > CH - 1) ? NMAX : nsel;
            mode_q <= mode;
            len_q  <= (len == '0) ? LW'(1) : len;
            qvld_q <= 1'b0;
        end else if (vld) begin
            acc_q[chn_q] <= sum_d;
            q_q          <= sum_d;
            qvld_q       <= !mode_q || blast;
            qch_q        <= chn_q;
            qlast_q      <= last;
            chn_q        <= chn_d;
            fcnt_q       <= fcnt_d;
        end else begin
            qvld_q <= 1'b0;
        end
    end

    assign q     = q_q;
    assign qvld  = qvld_q;
    assign qch   = qch_q;
    assign qlast = qlast_q;
endmodule

// File: tb/tb_int_mc.sv
// tb_int_mc: directed and randomized checks of int_mc against a frame-counting model.
module tb_int_mc;
    localparam int W = 64, CH = 4, CW = 2, LW = 16;

    logic          clk = 0, rst = 1, vld = 0, clr = 0, mode = 0;
    logic [W-1:0]  d = '0;
    logic [CW-1:0] nsel = '0;
    logic [LW-1:0] len = '0;
    logic [W-1:0]  q;
    logic          qvld, qlast;
    logic [CW-1:0] qch;

    int_mc #(.W(W), .CH(CH), .CW(CW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .d(d), .vld(vld), .clr(clr), .nsel(nsel),
        .mode(mode), .len(len), .q(q), .qvld(qvld), .qch(qch), .qlast(qlast)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // Model: channel and frame derive from the count of accepted samples since clr/reset.
    logic [W-1:0] macc [CH];
    int           mn, mmode, mlen, cnt, mqch;
    logic [W-1:0] mq;
    logic         mqlast;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear(input int n, input int m, input int l);
        for (int i = 0; i < CH; i++) macc[i] = '0;
        mn = (n > CH - 1 ? CH - 1 : n) + 1;
        mmode = m;
        mlen = (l == 0) ? 1 : l;
        cnt = 0;
    endtask

    task automatic step(input logic v, input logic [W-1:0] dv);
        int  ch, fr;
        logic ov;
        @(negedge clk);
        vld = v; d = dv; clr = 0;
        @(posedge clk);
        #1;
        ov = 0;
        if (v) begin
            ch = cnt % mn;
            fr = cnt / mn;
            if (mmode != 0 && fr % mlen == 0) macc[ch] = dv;
            else macc[ch] = macc[ch] + dv;
            mq = macc[ch];
            mqch = ch;
            mqlast = (ch == mn - 1);
            ov = (mmode == 0) || (fr % mlen == mlen - 1);
            cnt++;
        end
        chk("qvld", W'(qvld), W'(ov));
        chk("q", q, mq);
        chk("qch", W'(qch), W'(mqch));
        chk("qlast", W'(qlast), W'(mqlast));
    endtask

    task automatic clr_cfg(input int n, input int m, input int l, input logic v, input logic [W-1:0] dv);
        @(negedge clk);
        clr = 1; vld = v; d = dv;
        nsel = CW'(n); mode = m[0]; len = LW'(l);
        @(posedge clk);
        #1;
        chk("clr_qvld", W'(qvld), '0);
        model_clear(n, m, l);
        @(negedge clk);
        clr = 0; vld = 0;
        nsel = CW'($urandom); mode = 1'($urandom); len = LW'($urandom);
    endtask

    initial begin
        model_clear(CH - 1, 0, 1);
        mq = '0; mqch = 0; mqlast = 0;
        #2 rst = 0;
        #1;
        chk("rst_q", q, '0);
        chk("rst_qvld", W'(qvld), '0);
        @(negedge clk) rst = 1;
        step(1, 64'd7);
        step(1, 64'd8);
        step(1, 64'd9);
        // Reset mid-stream with vld high takes effect immediately
        @(negedge clk);
        vld = 1; d = 64'd55;
        #2 rst = 0;
        #1;
        chk("midrst_q", q, '0);
        chk("midrst_qvld", W'(qvld), '0);
        chk("midrst_qch", W'(qch), '0);
        chk("midrst_qlast", W'(qlast), '0);
        model_clear(CH - 1, 0, 1);
        mq = '0; mqch = 0; mqlast = 0;
        @(negedge clk);
        vld = 0; rst = 1;
        clr_cfg(3, 0, 1, 0, '0);
        step(1, 64'd4);
        chk("post_rst_qch", W'(qch), '0);

        clr_cfg(0, 0, 1, 0, '0);
        for (int k = 1; k <= 5; k++) begin
            step(1, 64'd1);
            chk("single_q", q, W'(k));
            chk("single_qlast", W'(qlast), 1);
        end

        clr_cfg(3, 0, 1, 0, '0);
        for (int f = 0; f < 3; f++)
            for (int c = 0; c < 4; c++) begin
                step(1, W'(c + 1));
                if (f == 2) chk("four_q", q, W'(3 * (c + 1)));
            end

        clr_cfg(0, 0, 1, 0, '0);
        step(1, '1);
        chk("wrap_q1", q, '1);
        step(1, 64'd2);
        chk("wrap_q2", q, 64'd1);

        clr_cfg(1, 1, 3, 0, '0);
        for (int f = 0; f < 6; f++)
            for (int c = 0; c < 2; c++) begin
                step(1, 64'd1);
                chk("dump_qvld", W'(qvld), W'(f == 2 || f == 5));
                if (f == 2 || f == 5) chk("dump_q", q, 64'd3);
            end

        clr_cfg(3, 0, 1, 0, '0);
        step(1, 64'd1);
        step(1, 64'd2);
        clr_cfg(3, 0, 1, 1, 64'd9);
        step(1, 64'd5);
        chk("clrmid_q", q, 64'd5);
        chk("clrmid_qch", W'(qch), '0);

        clr_cfg(2, 1, 0, 0, '0);
        for (int k = 0; k < 6; k++) begin
            step(1, W'(k * 11 + 3));
            chk("len0_q", q, W'(k * 11 + 3));
        end

        for (int r = 0; r < 10; r++) begin
            clr_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                    1'($urandom), {$urandom, $urandom});
            for (int k = 0; k < 60; k++)
                step($urandom_range(0, 9) < 7, (r % 3 == 0) ? W'($urandom_range(0, 20)) : {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/int_mc.md
# int_mc

Parametrised multi-channel integrator for channel-interleaved sample streams, successor to the fixed 64-bit 1/2-channel integrator in the decimation chain. Holds up to CH independent accumulators, integrates one sample per valid strobe into the current channel, and emits the updated sum one clock later. Supports continuous integration (CIC integrator section) and integrate-and-dump (boxcar) mode with a runtime block length.

## Interface
- W, 64: sample and accumulator width in bits.
- CH, 4: maximum channel count, ≥1.
- CW, clog2(CH) (min 1): channel index width.
- LW, 16: dump-length register width.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- d  in  W  input sample, two's complement.
- vld  in  1  d valid; one sample per asserted cycle.
- clr  in  1  synchronous clear and configuration load.
- nsel  in  CW  channel count minus 1, latched on clr.
- mode  in  1  0 = continuous, 1 = integrate-and-dump, latched on clr.
- len  in  LW  dump block length in frames, latched on clr.
- q  out  W  accumulator result.
- qvld  out  1  q valid strobe.
- qch  out  CW  channel of q.
- qlast  out  1  q belongs to the last channel of the frame.

## Operation
- Storage: acc[0..CH-1], W bits each. Channel counter chn, frame counter fcnt (LW bits), configuration registers nsel_r, mode_r, len_r.
- Reset (rst low, asynchronous): all acc, chn, fcnt = 0. q = 0, qvld = 0, qch = 0, qlast = 0. nsel_r = CH-1, mode_r = 0, len_r = 1.
- Effective channel count is nsel_r+1. nsel values above CH-1 are latched as CH-1. len value 0 is latched as 1.
- clr high: all acc, chn, fcnt = 0. Latch nsel, mode, len. qvld = 0 that cycle. clr has priority over vld, so a sample presented with clr is discarded.
- vld high, clr low:
  - Continuous mode: acc[chn] <= acc[chn] + d. q <= same sum. Sum is modulo 2^W; wrap is silent and required.
  - Dump mode, fcnt == 0: acc[chn] <= d, restarting the block.
  - Dump mode, fcnt != 0: acc[chn] <= acc[chn] + d.
  - Dump mode: q <= new acc value. qvld asserts only when fcnt == len_r-1. With len_r = 1, every sample is output and equals d.
  - qch <= chn. qlast <= (chn == nsel_r).
  - chn advances to chn+1. When chn == nsel_r it wraps to 0.
  - On chn wrap, fcnt advances to fcnt+1; in dump mode fcnt wraps to 0 when it reaches len_r-1. In continuous mode fcnt is held at 0.
- vld low: no state change. qvld = 0, and q/qch/qlast hold their last values.

## Timing
- Latency: sample on vld at edge t gives q/qvld at edge t+1.
- Throughput: one sample per clock sustained, including the 1-channel case where the same accumulator is updated on consecutive cycles. The read-modify-write completes in one clock with no hazard stall.
- Gaps in vld are allowed anywhere. Channel order is defined solely by the count of accepted samples.
- Configuration takes effect on the first vld after clr deasserts. nsel, mode and len are ignored when clr is low.
- Reset asserted mid-frame: all state is lost immediately. The first vld after rst rises is channel 0, frame 0.
- Adder is a single W-bit carry chain; the target is ≥200 MHz at W = 64.

## Test plan
- Reset: drive rst low mid-stream with vld high -> q = 0, qvld = 0, qch = 0 immediately. After release and clr with nsel = 3, the first output has qch = 0.
- Single channel, continuous: clr with nsel = 0, mode = 0, then d = 1 for 5 cycles back-to-back -> q = 1, 2, 3, 4, 5 on consecutive cycles, qlast = 1 on every output.
- Four channels, continuous: nsel = 3, d = 1, 2, 3, 4 repeated for 3 frames -> third frame q = 3, 6, 9, 12, qch = 0..3, qlast high on qch = 3 only.
- Wrap: nsel = 0, d = 2^64-1 then d = 2 -> q = 2^64-1 then q = 1.
- Dump: nsel = 1, mode = 1, len = 3, d = 1 on every sample for 6 frames -> qvld only on frames 2 and 5, each with q = 3 for ch0 and ch1, and qvld = 0 on all other samples.
- clr mid-frame: nsel = 3, feed 2 samples, assert clr with vld high and d = 9 -> d = 9 discarded. The next sample, d = 5, gives q = 5, qch = 0.
